// File: rtl/timing_pkg.sv
// Shared types and constants for the bunch-strobe acquisition sequencer.
// Optional build macro: STROBE_CHECK_EN enables the bunch-strobe count checker in timing_sequencer.
package timing_pkg;

    localparam int unsigned CFG_ADDR_W  = 3;
    localparam int unsigned CFG_DATA_W  = 16;
    localparam int unsigned CFG_DELAY_W = 16;
    localparam int unsigned WIN_W       = 8;
    localparam int unsigned WIN_CNT_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_STORE   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [CFG_ADDR_W-1:0] ADDR_B1_STROBE      = 3'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_B2_STROBE      = 3'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_NO_BUNCHES     = 3'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_NO_SAMPLES     = 3'd3;
    localparam logic [CFG_ADDR_W-1:0] ADDR_SAMPLE_SPACING = 3'd4;
    localparam logic [CFG_ADDR_W-1:0] ADDR_DELAY          = 3'd5;
    localparam logic [CFG_ADDR_W-1:0] ADDR_WIN_LEN        = 3'd6;

    localparam logic [7:0]       SPACING_RST = 8'd100;
    localparam logic [WIN_W-1:0] WIN_RST     = 8'd255;

    typedef struct packed {
        logic [7:0]             b1_strobe;
        logic [7:0]             b2_strobe;
        logic [1:0]             no_bunches;
        logic [3:0]             no_samples;
        logic [7:0]             sample_spacing;
        logic [CFG_DELAY_W-1:0] delay;
        logic [WIN_W-1:0]       win_len;
    } cfg_t;

    // A programmed window length of zero means the full 256-cycle window.
    function automatic logic [WIN_CNT_W-1:0] win_load(input logic [WIN_W-1:0] len);
        if (len == '0) begin
            return WIN_CNT_W'(256);
        end
        return WIN_CNT_W'(len);
    endfunction

endpackage

// File: rtl/timing_cfg_regs.sv
// Shadow configuration bank written by software, copied to the active bank on an accepted trigger.
module timing_cfg_regs
    import timing_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [CFG_ADDR_W-1:0] addr,
    input  logic [CFG_DATA_W-1:0] wdata,
    input  logic                  load,
    output cfg_t                  shadow,
    output cfg_t                  active
);

    // Software-visible shadow registers; unused addresses are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow                <= '0;
            shadow.sample_spacing <= SPACING_RST;
            shadow.win_len        <= WIN_RST;
        end else if (we) begin
            case (addr)
                ADDR_B1_STROBE:      shadow.b1_strobe      <= wdata[7:0];
                ADDR_B2_STROBE:      shadow.b2_strobe      <= wdata[7:0];
                ADDR_NO_BUNCHES:     shadow.no_bunches     <= wdata[1:0];
                ADDR_NO_SAMPLES:     shadow.no_samples     <= wdata[3:0];
                ADDR_SAMPLE_SPACING: shadow.sample_spacing <= wdata[7:0];
                ADDR_DELAY:          shadow.delay          <= CFG_DELAY_W'(wdata);
                ADDR_WIN_LEN:        shadow.win_len        <= wdata[WIN_W-1:0];
                default: ;
            endcase
        end
    end

    // Active bank only moves on load, so Timing sees stable config for the whole window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active                <= '0;
            active.sample_spacing <= SPACING_RST;
        end else if (load) begin
            active <= shadow;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Acquisition sequencer: trigger -> delay -> store_strb window -> holdoff -> re-arm or idle.
// Optional build macro: STROBE_CHECK_EN adds the bunch_strb edge counter behind bunch_err.
module timing_sequencer
    import timing_pkg::*;
#(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [CFG_DATA_W-1:0] cfg_wdata,
    input  logic                  arm,
    input  logic                  auto_rearm,
    input  logic                  abort,
    input  logic                  trig,
    input  logic                  bunch_strb,
    output logic                  store_strb,
    output logic [7:0]            b1_strobe,
    output logic [7:0]            b2_strobe,
    output logic [1:0]            no_bunches,
    output logic [3:0]            no_samples,
    output logic [7:0]            sample_spacing,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           win_count,
    output logic                  trig_overrun,
    output logic                  bunch_err
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t               state, state_n;
    logic                 trig_d, trig_rise;
    logic [DELAY_W-1:0]   dly_cnt;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 load_c, start_store_c, end_store_c, clr_flags_c, set_ovr_c;
    cfg_t                 shadow, active;
    logic                 unused_cfg;

    timing_cfg_regs u_cfg_regs (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we),
        .addr   (cfg_addr),
        .wdata  (cfg_wdata),
        .load   (load_c),
        .shadow (shadow),
        .active (active)
    );

    assign b1_strobe      = active.b1_strobe;
    assign b2_strobe      = active.b2_strobe;
    assign no_bunches     = active.no_bunches;
    assign no_samples     = active.no_samples;
    assign sample_spacing = active.sample_spacing;
    assign unused_cfg     = ^{shadow, active.delay};

    assign trig_rise = trig & ~trig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle control strobes; abort overrides every transition.
    always_comb begin
        state_n       = state;
        load_c        = 1'b0;
        start_store_c = 1'b0;
        end_store_c   = 1'b0;
        clr_flags_c   = 1'b0;
        set_ovr_c     = trig_rise &&
                        (state == ST_DELAY || state == ST_STORE || state == ST_HOLDOFF);
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state_n     = ST_ARMED;
                        clr_flags_c = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_rise) begin
                        state_n = ST_DELAY;
                        load_c  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt == '0) begin
                        state_n       = ST_STORE;
                        start_store_c = 1'b1;
                    end
                end
                ST_STORE: begin
                    if (win_cnt == WIN_CNT_W'(1)) begin
                        state_n     = ST_HOLDOFF;
                        end_store_c = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state_n = auto_rearm ? ST_ARMED : ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Delay, window and holdoff down-counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt  <= '0;
            win_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (load_c) begin
                dly_cnt <= DELAY_W'(shadow.delay);
            end else if (state == ST_DELAY && dly_cnt != '0) begin
                dly_cnt <= dly_cnt - DELAY_W'(1);
            end
            if (start_store_c) begin
                win_cnt <= win_load(active.win_len);
            end else if (state == ST_STORE) begin
                win_cnt <= win_cnt - WIN_CNT_W'(1);
            end
            if (end_store_c) begin
                hold_cnt <= HOLD_W'(HOLDOFF - 1);
            end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    // Registered outputs decoded from the next state so they align with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_strb   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            win_count    <= '0;
            trig_overrun <= 1'b0;
        end else begin
            store_strb <= (state_n == ST_STORE);
            busy       <= (state_n == ST_DELAY) || (state_n == ST_STORE) ||
                          (state_n == ST_HOLDOFF);
            done       <= end_store_c;
            if (end_store_c) begin
                win_count <= win_count + 16'd1;
            end
            if (clr_flags_c) begin
                trig_overrun <= 1'b0;
            end else if (set_ovr_c) begin
                trig_overrun <= 1'b1;
            end
        end
    end

`ifdef STROBE_CHECK_EN
    logic       bs_d, bedge, in_win;
    logic [2:0] bcnt, bcnt_nx;
    logic [1:0] post;

    // Edges are counted through STORE plus two trailing cycles of Timing pipeline latency.
    assign bedge   = bunch_strb & ~bs_d;
    assign in_win  = (state == ST_STORE) || (post != 2'd0);
    assign bcnt_nx = (bedge && in_win && bcnt != 3'd7) ? bcnt + 3'd1 : bcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bs_d      <= 1'b0;
            bcnt      <= '0;
            post      <= '0;
            bunch_err <= 1'b0;
        end else begin
            bs_d <= bunch_strb;
            if (load_c) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt_nx;
            end
            if (abort) begin
                post <= '0;
            end else if (end_store_c) begin
                post <= 2'd2;
            end else if (post != 2'd0) begin
                post <= post - 2'd1;
            end
            if (clr_flags_c) begin
                bunch_err <= 1'b0;
            end else if (post == 2'd1 && !abort && bcnt_nx != {1'b0, active.no_bunches}) begin
                bunch_err <= 1'b1;
            end
        end
    end
`else
    logic unused_bunch_strb;
    assign unused_bunch_strb = bunch_strb;
    assign bunch_err         = 1'b0;
`endif

endmodule
